// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN image loader: FSM state encoding,
// default image size, result-character base and the out-of-range character.
package snn_pkg;

  typedef enum logic [2:0] {
    WAIT_BYTE = 3'd0,
    SHIFT     = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    TX        = 3'd4,
    WAIT_TX   = 3'd5
  } snn_state_e;

  localparam int         DEF_NUM_PIXELS = 784;
  localparam logic [7:0] DEF_ASCII_ZERO = 8'h30;
  localparam logic [7:0] ERR_CHAR       = 8'h3F;

  // Digits 10..15 are not valid classes and map to the error character.
  function automatic logic [7:0] digit_to_char(input logic [3:0] digit,
                                                input logic [7:0] zero);
    return (digit <= 4'd9) ? zero + {4'h0, digit} : ERR_CHAR;
  endfunction

endpackage

// File: rtl/snn_byte_serializer.sv
// 8-bit load/shift register; bit_out presents bit 0 first, last flags the eighth bit.
module snn_byte_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       bit_out,
  output logic       last
);

  logic [7:0] shreg;
  logic [2:0] bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
    end else if (load) begin
      shreg   <= din;
      bit_idx <= 3'd0;
    end else if (shift) begin
      shreg   <= {1'b0, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  assign bit_out = shreg[0];
  assign last    = (bit_idx == 3'd7);

endmodule

// File: rtl/snn_input_loader.sv
// Loads a serial-received image into the 1-bit input RAM, starts the core and
// sends the result character. Optional rx_overrun flag: SNN_LOADER_OVERRUN_EN.
module snn_input_loader
  import snn_pkg::*;
#(
  parameter int         NUM_PIXELS = DEF_NUM_PIXELS,
  parameter logic [7:0] ASCII_ZERO = DEF_ASCII_ZERO
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic       ram_data,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
`ifdef SNN_LOADER_OVERRUN_EN
  output logic       rx_overrun,
`endif
  output logic [2:0] state_dbg
);

  // Handshakes: rx_rdy, core_done and tx_done are single-cycle strobes acted
  // on only in their waiting state; core_start and tx_start are single-cycle
  // registered strobes; there is no back-pressure on any interface.

  localparam int                NUM_BYTES = NUM_PIXELS / 8;
  localparam int                CNT_W     = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  snn_state_e       state, state_next;
  logic [CNT_W-1:0] byte_cnt;
  logic             load, shift, byte_inc, byte_clr, latch;
  logic             bit_out, last_bit;

  snn_byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .shift   (shift),
    .din     (rx_data),
    .bit_out (bit_out),
    .last    (last_bit)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    byte_inc   = 1'b0;
    byte_clr   = 1'b0;
    latch      = 1'b0;
    case (state)
      WAIT_BYTE: begin
        if (rx_rdy) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last_bit) begin
          byte_inc   = 1'b1;
          state_next = (byte_cnt == LAST_BYTE) ? START : WAIT_BYTE;
        end
      end
      START:     state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (core_done) begin
          latch      = 1'b1;
          state_next = TX;
        end
      end
      TX:        state_next = WAIT_TX;
      WAIT_TX: begin
        if (tx_done) begin
          byte_clr   = 1'b1;
          state_next = WAIT_BYTE;
        end
      end
      default:   state_next = WAIT_BYTE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_BYTE;
      byte_cnt <= '0;
    end else begin
      state <= state_next;
      if (byte_clr)
        byte_cnt <= '0;
      else if (byte_inc)
        byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  // Strobes are registered from the next state so they line up with the
  // state they belong to, giving one-cycle latency from rx_rdy and last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we     <= 1'b0;
      ram_addr   <= 10'd0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      ram_we     <= (state_next == SHIFT);
      core_start <= (state_next == START);
      tx_start   <= (state_next == TX);
      busy       <= (state_next != WAIT_BYTE);
      if (load)
        ram_addr <= 10'({byte_cnt, 3'b000});
      else if (shift && !last_bit)
        ram_addr <= ram_addr + 10'd1;
      if (latch)
        tx_data <= digit_to_char(core_digit, ASCII_ZERO);
    end
  end

  assign ram_data  = bit_out;
  assign state_dbg = state;

`ifdef SNN_LOADER_OVERRUN_EN
  logic drop;
  assign drop = rx_rdy && (state != WAIT_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rx_overrun <= 1'b0;
    else if (drop)
      rx_overrun <= 1'b1;
    else if (load && (byte_cnt == '0))
      rx_overrun <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed bench for snn_input_loader: per-image vector table plus reset,
// dropped-byte and stray core_done sequences.
module tb_snn_input_loader;
  import snn_pkg::*;

  localparam int NUM_BYTES = 98;

  typedef struct {
    logic [7:0] pattern;
    logic [3:0] digit;
    logic [7:0] exp_char;
    int         drop_off;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_data;
  logic       core_start;
  logic       core_done = 1'b0;
  logic [3:0] core_digit = 4'd0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic       busy;
  logic [2:0] state_dbg;
`ifdef SNN_LOADER_OVERRUN_EN
  logic       rx_overrun;
`endif

  snn_input_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .core_start (core_start),
    .core_done  (core_done),
    .core_digit (core_digit),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
`ifdef SNN_LOADER_OVERRUN_EN
    .rx_overrun (rx_overrun),
`endif
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt  = 0;
  int          cs_cnt  = 0;
  int          ts_cnt  = 0;
  int          exp_byte = 0;
  logic [10:0] exp_q[$];
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and score any RAM write / strobe seen there.
  task automatic tick();
    @(negedge clk);
    if (ram_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0b expected no write", ram_addr, ram_data);
      end else begin
        check("ram_write", {21'd0, ram_addr, ram_data}, {21'd0, exp_q.pop_front()});
      end
    end
    if (core_start) cs_cnt++;
    if (tx_start)   ts_cnt++;
  endtask

  // Drives one byte at max rate; drop_off in 2..8 injects a stray rx_rdy that
  // is sampled during SHIFT (8 = last shift cycle).
  task automatic send_byte(input logic [7:0] b, input int drop_off);
    for (int i = 0; i < 8; i++)
      exp_q.push_back({10'(exp_byte * 8 + i), b[i]});
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy = 1'b0;
    check("first_write_latency", {31'd0, ram_we}, 32'd1);
    check("first_write_addr", {22'd0, ram_addr}, 32'(exp_byte * 8));
    for (int k = 2; k <= 9; k++) begin
      tick();
      rx_rdy  = (k == drop_off);
      rx_data = ~b;
    end
    exp_byte++;
  endtask

  task automatic run_image(input vec_t v);
    int wr0, cs0, ts0;
    wr0 = wr_cnt;
    cs0 = cs_cnt;
    ts0 = ts_cnt;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (b == NUM_BYTES - 1) check("no_early_start", 32'(cs_cnt - cs0), 32'd0);
      send_byte(v.pattern, (b == 3) ? v.drop_off : 0);
`ifdef SNN_LOADER_OVERRUN_EN
      if (b == 0) check("overrun_clear", {31'd0, rx_overrun}, 32'd0);
      if (b == 3 && v.drop_off != 0) check("overrun_set_shift", {31'd0, rx_overrun}, 32'd1);
`endif
    end
    check("core_start_latency", {31'd0, core_start}, 32'd1);
    check("state_start", {29'd0, state_dbg}, {29'd0, START});
    check("write_count", 32'(wr_cnt - wr0), 32'(NUM_BYTES * 8));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("core_start_pulse", {31'd0, core_start}, 32'd0);
    // stray byte while the core runs must be dropped
    rx_rdy  = 1'b1;
    rx_data = 8'hFF;
    tick();
    rx_rdy = 1'b0;
`ifdef SNN_LOADER_OVERRUN_EN
    check("overrun_set_wait", {31'd0, rx_overrun}, 32'd1);
`endif
    repeat (3) tick();
    check("busy_wait_done", {31'd0, busy}, 32'd1);
    core_done  = 1'b1;
    core_digit = v.digit;
    tick();
    core_done  = 1'b0;
    core_digit = 4'd0;
    check("tx_start", {31'd0, tx_start}, 32'd1);
    check("tx_data", {24'd0, tx_data}, {24'd0, v.exp_char});
    repeat (4) tick();
    check("tx_data_hold", {24'd0, tx_data}, {24'd0, v.exp_char});
    check("busy_wait_tx", {31'd0, busy}, 32'd1);
    check("one_core_start", 32'(cs_cnt - cs0), 32'd1);
    check("one_tx_start", 32'(ts_cnt - ts0), 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("state_idle", {29'd0, state_dbg}, {29'd0, WAIT_BYTE});
    exp_byte = 0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 4'd7,  8'h37, 0};
    vecs[1] = '{8'hA5, 4'd12, 8'h3F, 3};
    vecs[2] = '{8'h00, 4'd0,  8'h30, 0};
    vecs[3] = '{8'hFF, 4'd9,  8'h39, 8};
    vecs[4] = '{8'h3C, 4'd10, 8'h3F, 0};
    vecs[5] = '{8'h81, 4'd15, 8'h3F, 0};

    repeat (3) tick();
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // core_done while idle must be ignored
    core_done  = 1'b1;
    core_digit = 4'd3;
    repeat (4) tick();
    core_done = 1'b0;
    check("idle_core_done_state", {29'd0, state_dbg}, {29'd0, WAIT_BYTE});
    check("idle_core_done_tx", 32'(ts_cnt), 32'd0);
    check("idle_core_done_data", {24'd0, tx_data}, 32'd0);
    check("idle_core_done_busy", {31'd0, busy}, 32'd0);

    for (int v = 0; v < 6; v++) run_image(vecs[v]);

    // reset part-way through byte 51 discards the partial image
    for (int b = 0; b < 50; b++) send_byte(8'h5A, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back({10'(exp_byte * 8 + i), 1'b0});
    rx_rdy  = 1'b1;
    rx_data = 8'h00;
    tick();
    rx_rdy = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("async_rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    check("async_rst_ram_data", {31'd0, ram_data}, 32'd0);
    check("async_rst_core_start", {31'd0, core_start}, 32'd0);
    check("async_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("async_rst_state", {29'd0, state_dbg}, {29'd0, WAIT_BYTE});
    exp_q.delete();
    exp_byte = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_image('{8'hA5, 4'd3, 8'h33, 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
